// File: rtl/flock_sequencer.sv
// Per-frame erase/update/redraw plot sequencer for up to four duck sprites.
// Emits one adapter pixel per clock and owns bird positions and respawn LFSR.
module flock_sequencer #(
  parameter int NUM_BIRDS = 4,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter logic [2:0] DRAW_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       enable,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE, ERASE, UPDATE, DRAW, DONE
  } state_t;

  localparam logic [2:0] END_B = 3'(NUM_BIRDS);
  localparam logic signed [8:0] YM = 9'(Y_MAX);

  state_t     state;
  logic [7:0] lfsr;
  logic [2:0] b;
  logic [3:0] k;
  logic [7:0] bx   [NUM_BIRDS];
  logic [6:0] by   [NUM_BIRDS];
  logic [7:0] bx_n [NUM_BIRDS];
  logic [6:0] by_n [NUM_BIRDS];

  always_comb begin
    for (int i = 0; i < NUM_BIRDS; i++) begin
      bx_n[i] = bx[i];
      by_n[i] = by[i];
      if (enable) begin
        if (bx[i] == 8'(X_MAX)) begin
          bx_n[i] = 8'd0;
          by_n[i] = 7'd16 + {1'b0, lfsr[5:0] ^ 6'(i)};
        end else begin
          bx_n[i] = bx[i] + 8'd1;
        end
      end
    end
  end

  // UPDATE emits the first draw pixel, so it must see the new positions
  logic [7:0] cx;
  logic [6:0] cy;
  always_comb begin
    cx = 8'd0;
    cy = 7'd0;
    for (int i = 0; i < NUM_BIRDS; i++) begin
      if (3'(i) == b) begin
        cx = (state == UPDATE) ? bx_n[i] : bx[i];
        cy = (state == UPDATE) ? by_n[i] : by[i];
      end
    end
  end

  logic signed [8:0] dx, dy, sx, sy;
  always_comb begin
    case (k)
      4'd0:    begin dx = 9'sd0;  dy = 9'sd0;  end
      4'd1:    begin dx = 9'sd0;  dy = 9'sd1;  end
      4'd2:    begin dx = -9'sd1; dy = 9'sd0;  end
      4'd3:    begin dx = -9'sd2; dy = 9'sd0;  end
      4'd4:    begin dx = -9'sd3; dy = 9'sd0;  end
      4'd5:    begin dx = -9'sd4; dy = 9'sd0;  end
      4'd6:    begin dx = -9'sd5; dy = 9'sd0;  end
      4'd7:    begin dx = -9'sd3; dy = 9'sd1;  end
      4'd8:    begin dx = -9'sd3; dy = -9'sd1; end
      4'd9:    begin dx = -9'sd4; dy = 9'sd2;  end
      4'd10:   begin dx = -9'sd4; dy = -9'sd2; end
      4'd11:   begin dx = -9'sd5; dy = 9'sd3;  end
      default: begin dx = -9'sd5; dy = -9'sd3; end
    endcase
    sx = $signed({1'b0, cx}) + dx;
    sy = $signed({2'b0, cy}) + dy;
  end

  logic       vis;
  logic [7:0] ox;
  logic [6:0] oy;
  logic [2:0] oc;
  logic       last_k;
  always_comb begin
    vis = !sx[8] && !sy[8] && (sy <= YM);
    ox = vis ? sx[7:0] : 8'd0;
    oy = vis ? sy[6:0] : 7'd0;
    oc = 3'd0;
    if (vis) oc = (state == IDLE || state == ERASE) ? BG_COLOUR : DRAW_COLOUR;
    last_k = (k == 4'd12);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      lfsr <= 8'hA5;
      b <= 3'd0;
      k <= 4'd0;
      x <= 8'd0;
      y <= 7'd0;
      colour <= 3'd0;
      plot <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_BIRDS; i++) begin
        bx[i] <= 8'(40 * i);
        by[i] <= 7'(16 + 24 * i);
      end
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (frame_tick && busy) overrun <= 1'b1;
      x <= 8'd0;
      y <= 7'd0;
      colour <= 3'd0;
      plot <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (frame_tick) begin
          state <= ERASE;
          busy <= 1'b1;
          plot <= vis;
          x <= ox;
          y <= oy;
          colour <= oc;
          k <= 4'd1;
        end
        ERASE, DRAW: begin
          if (b == END_B) begin
            state <= (state == ERASE) ? UPDATE : DONE;
            frame_done <= (state == DRAW);
            b <= 3'd0;
            k <= 4'd0;
          end else begin
            plot <= vis;
            x <= ox;
            y <= oy;
            colour <= oc;
            b <= last_k ? b + 3'd1 : b;
            k <= last_k ? 4'd0 : k + 4'd1;
          end
        end
        UPDATE: begin
          state <= DRAW;
          for (int i = 0; i < NUM_BIRDS; i++) begin
            bx[i] <= bx_n[i];
            by[i] <= by_n[i];
          end
          plot <= vis;
          x <= ox;
          y <= oy;
          colour <= oc;
          k <= 4'd1;
        end
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flock_sequencer.sv
// Randomized frame sequences against a cycle-level reference of the plot stream.
// Expected per-cycle outputs are queued at tick time and popped while busy.
module tb_flock_sequencer;

  localparam int N = 4;
  localparam int CYC = 26 * N + 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, frame_done, overrun;

  always #5 clock = ~clock;

  flock_sequencer #(.NUM_BIRDS(N)) dut (
    .clock(clock),
    .resetn(resetn),
    .frame_tick(frame_tick),
    .enable(enable),
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun)
  );

  typedef struct packed {
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       done;
    logic       ovr;
  } rec_t;

  rec_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   steps;
  int   mx[N];
  int   my[N];
  bit   movr;
  int   DX[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
  int   DY[13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

  always @(posedge clock or negedge resetn)
    if (!resetn) steps <= 0;
    else steps <= steps + 1;

  function automatic logic [7:0] lfsr_at(int n);
    logic [7:0] l = 8'hA5;
    repeat (n) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  function automatic rec_t pix(int bi, int kk, logic [2:0] col, bit ov);
    rec_t r = '0;
    int px = mx[bi] + DX[kk];
    int py = my[bi] + DY[kk];
    r.ovr = ov;
    if (px >= 0 && py >= 0 && py <= 119) begin
      r.plot = 1'b1;
      r.x = 8'(px);
      r.y = 7'(py);
      r.colour = col;
    end
    return r;
  endfunction

  task automatic check(string name, rec_t act, rec_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got plot=%0b x=%0d y=%0d col=%0d done=%0b ovr=%0b, want plot=%0b x=%0d y=%0d col=%0d done=%0b ovr=%0b",
               name, act.plot, act.x, act.y, act.colour, act.done, act.ovr,
               exp.plot, exp.x, exp.y, exp.colour, exp.done, exp.ovr);
    end
  endtask

  function automatic rec_t outs();
    return {plot, x, y, colour, frame_done, overrun};
  endfunction

  always @(negedge clock) begin
    if (resetn && busy) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL extra_busy: busy=1 with no expected cycle, want busy=0");
      end else begin
        check("cycle", outs(), q.pop_front());
      end
    end else if (resetn && plot) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_plot: plot=1 while idle, want 0");
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 40 * i;
      my[i] = 16 + 24 * i;
    end
    movr = 0;
  endtask

  task automatic run_frame(bit en, int cx, int abort_c);
    rec_t r;
    logic [7:0] l;
    @(negedge clock);
    frame_tick = 1'b1;
    enable = en;
    l = lfsr_at(steps + 13 * N + 1);
    for (int bi = 0; bi < N; bi++)
      for (int kk = 0; kk < 13; kk++)
        q.push_back(pix(bi, kk, 3'b000, movr || (cx >= 0 && bi * 13 + kk > cx)));
    r = '0;
    r.ovr = movr || (cx >= 0 && 13 * N > cx);
    q.push_back(r);
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (mx[i] == 159) begin
          mx[i] = 0;
          my[i] = 16 + int'(l[5:0] ^ 6'(i));
        end else begin
          mx[i] = mx[i] + 1;
        end
      end
    end
    for (int bi = 0; bi < N; bi++)
      for (int kk = 0; kk < 13; kk++)
        q.push_back(pix(bi, kk, 3'b110,
                        movr || (cx >= 0 && 13 * N + 1 + bi * 13 + kk > cx)));
    r = '0;
    r.done = 1'b1;
    r.ovr = movr || (cx >= 0 && CYC - 1 > cx);
    q.push_back(r);
    @(posedge clock);
    #1;
    for (int c = 0; c < CYC; c++) begin
      if (c == abort_c) begin
        #1 resetn = 1'b0;
        frame_tick = 1'b0;
        #1 check("abort_outs", outs(), '0);
        vectors++;
        if (busy !== 1'b0) begin
          miscompares++;
          $display("FAIL abort_busy: got %b want 0", busy);
        end
        q.delete();
        model_reset();
        @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        return;
      end
      frame_tick = (c == cx);
      @(posedge clock);
      #1;
    end
    frame_tick = 1'b0;
    if (cx >= 0) movr = 1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL frame_len: %0d expected cycles left, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    model_reset();
    enable = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    check("reset_outs", outs(), '0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_overrun: got %b want 0", overrun);
    end

    repeat (3) run_frame(1'b0, -1, -1);
    run_frame(1'b1, 50, -1);
    for (int f = 0; f < 165; f++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_frame(1'b1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, CYC - 1)) : -1, -1);
    end
    for (int f = 0; f < 20; f++)
      run_frame(1'($urandom_range(0, 1)), -1, -1);
    run_frame(1'b1, -1, 13 * N + 1 + 40);
    repeat (2) run_frame(1'b1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flock_sequencer.md
# flock_sequencer

Per-frame plot controller between `frame_counter` and `vga_adapter`. On each accepted frame tick it erases every bird sprite at its current position, advances all bird positions, and redraws every sprite, emitting one pixel per clock on the adapter's `x`/`y`/`colour`/`plot` inputs. It owns the bird position state for up to four birds, the 13-pixel duck sprite walk, and a free-running LFSR for respawn heights.

## Interface
- `NUM_BIRDS`, 4: number of birds; legal range 1..4.
- `X_MAX`, 159: last visible column.
- `Y_MAX`, 119: last visible row.
- `DRAW_COLOUR`, 3'b110: sprite colour.
- `BG_COLOUR`, 3'b000: erase colour.

Ports:
- `clock` in 1: system clock (CLOCK_50 domain).
- `resetn` in 1: reset, asynchronous, active-low.
- `frame_tick` in 1: one-cycle frame pulse from `frame_counter`.
- `enable` in 1: high = positions advance in UPDATE; low = freeze (redraw still happens).
- `x` out 8: pixel column to adapter.
- `y` out 7: pixel row to adapter.
- `colour` out 3: pixel colour to adapter.
- `plot` out 1: pixel write strobe.
- `busy` out 1: state != IDLE.
- `frame_done` out 1: one-cycle pulse at end of frame sequence.
- `overrun` out 1: sticky; `frame_tick` seen while busy.

## Operation
- States: IDLE, ERASE, UPDATE, DRAW, DONE.
- Transitions:
  - IDLE → ERASE on `frame_tick`.
  - ERASE → UPDATE after pixel 13·N−1.
  - UPDATE → DRAW after 1 cycle.
  - DRAW → DONE after pixel 13·N−1.
  - DONE → IDLE after 1 cycle.
- Pixel walk order: bird 0..N−1; within a bird, offsets k = 0..12 (dx, dy):
  - (0,0), (0,+1), (−1,0), (−2,0), (−3,0), (−4,0), (−5,0)
  - (−3,+1), (−3,−1), (−4,+2), (−4,−2), (−5,+3), (−5,−3)
- Coordinates: computed in 9-bit signed arithmetic.
  - If x+dx < 0, or y+dy < 0, or y+dy > Y_MAX: pixel is clipped. `plot`=0 and `x`=`y`=0 that cycle; the walk still takes the cycle.
- Colour: BG_COLOUR in ERASE, DRAW_COLOUR in DRAW. `colour`=0 whenever `plot`=0.
- Initial positions (reset): x_i = 40·i, y_i = 16 + 24·i.
- UPDATE (all birds in the same cycle, only if `enable`):
  - x_i < X_MAX: x_i ← x_i + 1.
  - x_i = X_MAX: x_i ← 0 and y_i ← 16 + (lfsr[5:0] ^ i), a 6-bit XOR with zero-extended i.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advances every clock regardless of state.
- `overrun`: set when `frame_tick`=1 while `busy`=1; that tick is dropped. Cleared only by reset.
- `frame_tick` arriving in DONE is also dropped and sets `overrun`.

## Timing
- All outputs are registered.
- Reset values: `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `frame_done`=0, `overrun`=0, state=IDLE, positions initial, lfsr=8'hA5.
- Let edge E0 sample `frame_tick`=1 in IDLE; cycle c is the c-th cycle after E0 (c=0 first).
  - Cycles 0..13N−1: erase pixel c on outputs.
  - Cycle 13N: UPDATE, `plot`=0. Positions take new values at the edge ending this cycle.
  - Cycles 13N+1..26N: draw pixel (c−13N−1), using updated positions.
  - Cycle 26N+1: DONE, `frame_done`=1, `plot`=0.
  - `busy`=1 for cycles 0..26N+1 (26N+2 cycles). Next tick is accepted no earlier than cycle 26N+2.
- `resetn` low at any point: immediately (asynchronously) IDLE, all outputs and state take reset values. A partial frame is abandoned, not completed.
- Simultaneous wrap of several birds: each uses the same lfsr value XOR its own index.

## Test plan
- Reset: hold `resetn`=0, pulse `frame_tick` → all outputs 0, `busy`=0, no `plot`; release, check `overrun`=0.
- NUM_BIRDS=1, `enable`=1, single tick after reset:
  - Cycle 0: (0,16), BG.
  - Cycle 1: (0,17).
  - Cycles 2..12: `plot`=0 (clipped).
  - Cycle 13: UPDATE, `plot`=0.
  - Cycle 14: draw (1,16), colour 110.
  - Cycle 15: (1,17).
  - Cycle 16: (0,16).
  - Cycle 27: `frame_done`=1.
- Wrap: NUM_BIRDS=1, 160 frames with `enable`=1 → after frame 159 x=159; frame 160 UPDATE gives x=0, y=16+(lfsr[5:0]) matching a reference-model LFSR sampled that cycle.
- `enable`=0 over 3 frames → erase and draw coordinates are identical each frame; positions unchanged.
- Overrun: NUM_BIRDS=4, second tick at cycle 50 → ignored, `overrun`=1 stays set, frame still ends with `frame_done` at cycle 105.
- Reset mid-frame: drop `resetn` at cycle 40 of DRAW → `plot`=0 at once; after release, next tick erases at initial positions (0,16),(40,40),…
